xg_mem_arbiter: RTL

- Shares one single-port unified memory between the pipeline's instruction-fetch (I) and data (D) ports.
- Grants one requester at a time and sequences the memory handshake, including variable-latency memories.
- Produces per-port stall signals for the pipeline hazard logic.
- Includes a starvation guard for fetch and a watchdog timeout for memories that never acknowledge.

---
 rtl/xg_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/xg_mem_arbiter.sv
// Arbitrates one single-port memory between instruction-fetch (I) and data (D) requesters,
// with D priority, a fetch starvation guard and a watchdog for memories that never acknowledge.
module xg_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                clk,
   input  logic                rstn,
   // fetch port
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   output logic                i_err,
   output logic                i_stall,
   // data port
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   output logic                d_stall,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                busy
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t     state, state_nxt;
   logic       gnt_d;
   logic [3:0] starve_cnt;
   logic [7:0] tcnt;
   logic       pick_d, pick_i, take;
   logic       done_ok, done_to;

   // D wins unless fetch has already been passed over STARVE_LIMIT times in a row
   always_comb begin
      pick_d  = d_req & ~(i_req & (starve_cnt == STARVE_MAX));
      pick_i  = i_req & ~pick_d;
      take    = (state == IDLE) & (i_req | d_req);
      done_ok = (state == BUSY) & mem_ack;
      done_to = (state == BUSY) & ~mem_ack & (tcnt == TCNT_LAST);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = BUSY;
         BUSY:    if (done_ok || done_to) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture: the granted port is copied onto the memory bus for the whole access
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_d      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
         starve_cnt <= '0;
      end else if (take) begin
         gnt_d     <= pick_d;
         mem_req   <= 1'b1;
         mem_we    <= pick_d & d_we;
         mem_addr  <= pick_d ? d_addr  : i_addr;
         mem_wdata <= pick_d ? d_wdata : '0;
         mem_wmask <= pick_d ? d_wmask : '0;
         if (pick_i || !i_req) starve_cnt <= '0;
         else                  starve_cnt <= starve_cnt + 4'd1;
      end else if (done_ok || done_to) begin
         mem_req <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  tcnt <= '0;
      else if (take)              tcnt <= '0;
      else if (state == BUSY && !mem_ack && tcnt != TCNT_LAST) tcnt <= tcnt + 8'd1;
   end

   // Response capture: rdata/err are held until that port's next completion
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         i_rdata <= '0;
         i_err   <= 1'b0;
         i_ack   <= 1'b0;
         d_rdata <= '0;
         d_err   <= 1'b0;
         d_ack   <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (done_ok || done_to) begin
            if (gnt_d) begin
               d_rdata <= done_ok ? mem_rdata : '0;
               d_err   <= done_to;
               d_ack   <= 1'b1;
            end else begin
               i_rdata <= done_ok ? mem_rdata : '0;
               i_err   <= done_to;
               i_ack   <= 1'b1;
            end
         end
      end
   end

   assign i_stall = i_req & ~i_ack;
   assign d_stall = d_req & ~d_ack;
   assign busy    = (state != IDLE);

endmodule
